// File: rtl/gate_exerciser_pkg.sv
// Shared types and the golden gate model for the gate exerciser.
package gate_exerciser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int unsigned RES_W    = 7;
  localparam int unsigned IDX_AND  = 0;
  localparam int unsigned IDX_NAND = 1;
  localparam int unsigned IDX_OR   = 2;
  localparam int unsigned IDX_NOR  = 3;
  localparam int unsigned IDX_XOR  = 4;
  localparam int unsigned IDX_XNOR = 5;
  localparam int unsigned IDX_NOT  = 6;

  function automatic logic [RES_W-1:0] gate_expected(input logic a, input logic b);
    logic [RES_W-1:0] e;
    e           = '0;
    e[IDX_AND]  = a & b;
    e[IDX_NAND] = ~(a & b);
    e[IDX_OR]   = a | b;
    e[IDX_NOR]  = ~(a | b);
    e[IDX_XOR]  = a ^ b;
    e[IDX_XNOR] = ~(a ^ b);
    e[IDX_NOT]  = ~a;
    return e;
  endfunction

endpackage

// File: rtl/gate_exerciser_popcount7.sv
// Combinational population count of a 7-bit mismatch vector.
module gate_exerciser_popcount7 (
  input  logic [6:0] i_bits,
  output logic [2:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      o_count = o_count + {2'b00, i_bits[i]};
    end
  end

endmodule

// File: rtl/gate_exerciser.sv
// Self-test harness for a two-input gate block: sweeps ab=00..11, checks seven results.
// Optional macro GATE_EXERCISER_LOOP_EN: repeat passes while start stays high.
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a_o,
  output logic                 b_o,
  input  logic [6:0]           result_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [6:0]           fail_mask
);

  localparam int unsigned      CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_vec;
  logic [CNT_W-1:0]     r_cnt;
  logic [ERR_CNT_W-1:0] r_err;
  logic [RES_W-1:0]     r_mask;
  logic                 r_pass;

  logic [RES_W-1:0]     w_mismatch;
  logic [2:0]           w_pop;
  logic [ERR_CNT_W:0]   w_sum;
  logic [ERR_CNT_W-1:0] w_err_next;
  logic                 w_loop;
  logic                 w_last;

  assign w_mismatch = gate_expected(r_vec[1], r_vec[0]) ^ result_i;

  gate_exerciser_popcount7 u_pop (
    .i_bits  (w_mismatch),
    .o_count (w_pop)
  );

  // One spare MSB catches the carry; any carry clamps to all-ones.
  assign w_sum      = {1'b0, r_err} + (ERR_CNT_W + 1)'(w_pop);
  assign w_err_next = w_sum[ERR_CNT_W] ? '1 : w_sum[ERR_CNT_W-1:0];

`ifdef GATE_EXERCISER_LOOP_EN
  assign w_loop = start;
`else
  assign w_loop = 1'b0;
`endif

  assign w_last = (r_vec == 2'd3) && !w_loop;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SETTLE;
      SETTLE:  if (r_cnt == '0) w_next = CHECK;
      CHECK:   w_next = w_last ? DONE : SETTLE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec  <= '0;
      r_cnt  <= '0;
      r_err  <= '0;
      r_mask <= '0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_err  <= '0;
            r_mask <= '0;
            r_pass <= 1'b0;
            r_vec  <= '0;
            r_cnt  <= CNT_LOAD;
          end
        end
        SETTLE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        CHECK: begin
          r_mask <= r_mask | w_mismatch;
          r_err  <= w_err_next;
          // vec 3 -> 0 here only happens in loop mode (w_last false).
          if (!w_last) begin
            r_vec <= r_vec + 2'd1;
            r_cnt <= CNT_LOAD;
          end
        end
        DONE: begin
          r_pass <= (r_err == '0);
        end
        default: ;
      endcase
    end
  end

  assign a_o       = r_vec[1];
  assign b_o       = r_vec[0];
  assign busy      = (r_state == SETTLE) || (r_state == CHECK);
  assign done      = (r_state == DONE);
  assign pass      = r_pass;
  assign err_cnt   = r_err;
  assign fail_mask = r_mask;

endmodule

// File: tb/tb_gate_exerciser.sv
// Self-checking bench for gate_exerciser with a faultable behavioural gate block.
module tb_gate_exerciser;

  localparam int unsigned ERR_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             a_o;
  logic             b_o;
  logic [6:0]       result_i;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [6:0]       fail_mask;

  logic [1:0]       fault_mode;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [ERR_W-1:0] err;
    logic [6:0]       mask;
    logic             pass;
  } exp_t;

  typedef struct {
    logic [1:0] fault;
    int         restart;
    exp_t       e;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[5];

  gate_exerciser #(
    .SETTLE_CYCLES (2),
    .ERR_CNT_W     (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_o       (a_o),
    .b_o       (b_o),
    .result_i  (result_i),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .fail_mask (fail_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate block: 0 good, 1 and stuck-0, 2 xor/xnor swapped, 3 all inverted.
  always_comb begin
    result_i[0] = a_o & b_o;
    result_i[1] = ~(a_o & b_o);
    result_i[2] = a_o | b_o;
    result_i[3] = ~(a_o | b_o);
    result_i[4] = a_o ^ b_o;
    result_i[5] = ~(a_o ^ b_o);
    result_i[6] = ~a_o;
    case (fault_mode)
      2'd1: result_i[0] = 1'b0;
      2'd2: begin
        result_i[4] = ~(a_o ^ b_o);
        result_i[5] = a_o ^ b_o;
      end
      2'd3: result_i = ~{~a_o, ~(a_o ^ b_o), a_o ^ b_o, ~(a_o | b_o),
                         a_o | b_o, ~(a_o & b_o), a_o & b_o};
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic run_pass(input logic [1:0] fault, input int restart, input exp_t e);
    exp_t got;
    bit   have = 0;
    fault_mode = fault;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(n <= 12));
      chk("done", 32'(done), 32'(n == 13));
      if (n % 3 == 0 && n <= 12) chk("vec", 32'({a_o, b_o}), 32'(n / 3 - 1));
      if (n == 1) chk("pass_clr", 32'(pass), 32'(0));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(1), 32'(0));
        end else begin
          got  = exp_q.pop_front();
          have = 1;
          chk("err_cnt", 32'(err_cnt), 32'(got.err));
          chk("fail_mask", 32'(fail_mask), 32'(got.mask));
        end
      end
      if (n == 14 && have) chk("pass", 32'(pass), 32'(got.pass));
      if (n == restart) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
  endtask

  initial begin
    tbl[0] = '{fault: 2'd0, restart: 0, e: '{err: 4'd0,  mask: 7'h00, pass: 1'b1}};
    tbl[1] = '{fault: 2'd1, restart: 0, e: '{err: 4'd1,  mask: 7'h01, pass: 1'b0}};
    tbl[2] = '{fault: 2'd2, restart: 0, e: '{err: 4'd8,  mask: 7'h30, pass: 1'b0}};
    tbl[3] = '{fault: 2'd3, restart: 0, e: '{err: 4'd15, mask: 7'h7F, pass: 1'b0}};
    tbl[4] = '{fault: 2'd0, restart: 5, e: '{err: 4'd0,  mask: 7'h00, pass: 1'b1}};

    rst        = 1'b1;
    start      = 1'b0;
    fault_mode = 2'd0;
    #13;
    chk("reset_outputs", 32'({a_o, b_o, busy, done, pass, err_cnt, fail_mask}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'(0));

    for (int i = 0; i < 5; i++) run_pass(tbl[i].fault, tbl[i].restart, tbl[i].e);

`ifdef GATE_EXERCISER_LOOP_EN
    begin : loop_held
      exp_t got;
      fault_mode = 2'd3;
      exp_q.push_back('{err: 4'd15, mask: 7'h7F, pass: 1'b0});
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 26; n++) begin
        @(negedge clk);
        if (n == 4)  chk("loop_err1", 32'(err_cnt), 32'(7));
        if (n == 7)  chk("loop_err2", 32'(err_cnt), 32'(14));
        if (n == 10) chk("loop_err3", 32'(err_cnt), 32'(15));
        if (n == 13) chk("loop_busy", 32'(busy), 32'(1));
        if (n == 16) chk("loop_sat", 32'(err_cnt), 32'(15));
        if (n == 20) start = 1'b0;
        chk("loop_done", 32'(done), 32'(n == 25));
        if (done && exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("loop_err_final", 32'(err_cnt), 32'(got.err));
          chk("loop_mask", 32'(fail_mask), 32'(got.mask));
        end
        if (n == 26) chk("loop_pass", 32'(pass), 32'(0));
      end
    end
`else
    begin : held_start
      int waited;
      fault_mode = 2'd0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 15; n++) begin
        @(negedge clk);
        if (n == 13) chk("held_done", 32'(done), 32'(1));
        if (n == 14) chk("held_idle", 32'(busy), 32'(0));
        if (n == 15) chk("held_relaunch", 32'(busy), 32'(1));
      end
      start  = 1'b0;
      waited = 0;
      while (!done && waited < 30) begin
        @(negedge clk);
        waited++;
      end
      chk("held_second_done", 32'(done), 32'(1));
      @(negedge clk);
      chk("held_no_third", 32'(busy), 32'(0));
    end
`endif

    begin : reset_mid
      int done_seen;
      fault_mode = 2'd3;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 4; n++) @(negedge clk);
      chk("pre_rst_err", 32'(err_cnt), 32'(7));
      rst = 1'b1;
      #1;
      chk("rst_outputs", 32'({a_o, b_o, busy, done, pass, err_cnt, fail_mask}), 32'(0));
      @(negedge clk);
      rst       = 1'b0;
      done_seen = 0;
      for (int n = 0; n < 15; n++) begin
        @(negedge clk);
        if (done || busy) done_seen++;
      end
      chk("rst_no_done", 32'(done_seen), 32'(0));
    end

    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Sequential stimulus/response end of the two-input logic-gate interface.
- Drives `a_o`/`b_o` to a gate block through all four input combinations in order 00, 01, 10, 11, with `a_o` as the MSB of the combination.
- Waits a programmable settle time, then samples the seven gate results. It compares them against a golden model and accumulates a per-output fail mask and a mismatch count.
- Used as the on-chip self-test harness for the gate block; `done`/`pass` go to status LEDs or a host.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling `result_i`; minimum 1.
- ERR_CNT_W, 8, width of the mismatch counter; the counter saturates at all-ones.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a test pass; sampled in IDLE only.
- a_o  output  1  gate input a stimulus.
- b_o  output  1  gate input b stimulus.
- result_i  input  7  gate results: [0] and, [1] nand, [2] or, [3] nor, [4] xor, [5] xnor, [6] not(a).
- busy  output  1  high in SETTLE and CHECK.
- done  output  1  one-cycle pulse, high while in DONE.
- pass  output  1  1 when `err_cnt == 0` at the end of the last pass; held until the next start.
- err_cnt  output  ERR_CNT_W  total mismatching result bits, saturating.
- fail_mask  output  7  sticky OR of mismatching bit positions.

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values: state=IDLE, vec=0, a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=0, settle counter=0.
- Registers: state, vec[1:0], settle counter, err_cnt, fail_mask, pass. All outputs are registered or Moore-decoded from state.
- State IDLE:
  - If start=1: clear err_cnt and fail_mask, clear pass, set vec=0, drive a_o=0/b_o=0, load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- State SETTLE:
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- State CHECK (one cycle):
  - Compute expected = {~a, ~(a^b), a^b, ~(a|b), a|b, ~(a&b), a&b} from the registered a_o/b_o.
  - Compute mismatch = expected ^ result_i.
  - Update fail_mask |= mismatch.
  - Update err_cnt += popcount(mismatch), saturating at 2^ERR_CNT_W-1.
  - If vec==3, go to DONE. Otherwise increment vec, drive {a_o,b_o}=vec+1 on the same edge, reload the settle counter, and go to SETTLE.
- State DONE (one cycle):
  - done=1.
  - pass is set to (err_cnt==0) using the final count, including the last CHECK.
  - Go to IDLE.
- Latency: for a start sampled at cycle 0, done is high in cycle 4*(SETTLE_CYCLES+1)+1. For the default SETTLE_CYCLES=2 this is cycle 13.
- Boundaries:
  - start during busy or DONE is ignored; it is neither queued nor a restart.
  - start held high in IDLE launches exactly one pass per IDLE visit.
  - Saturation: err_cnt stops at max and does not wrap.
  - vec wraps only through IDLE.
  - Reset asserted mid-pass returns immediately to IDLE with all reset values; the partial result is discarded.
  - result_i is ignored outside CHECK.

Optional Feature:
- Macro: GATE_EXERCISER_LOOP_EN.
- Defined (loop mode):
  - In CHECK with vec==3 and start still high, the block skips DONE. It wraps vec to 0, drives 00 and returns to SETTLE.
  - err_cnt and fail_mask keep accumulating (err_cnt saturating) across passes.
  - When start is low at the vec==3 CHECK, the block goes to DONE as normal.
- Not defined: single pass per start, exactly as in Behaviour.

Decomposition:
- Package gate_exerciser_pkg holds:
  - state enum (IDLE, SETTLE, CHECK, DONE);
  - result bit index constants (IDX_AND..IDX_NOT);
  - RES_W=7;
  - function gate_expected(a,b) returning the 7-bit golden vector.
- One sub-module is natural: popcount7 (combinational, 7-bit in, 3-bit count out), feeding the saturating adder.

Test Plan:
- Correct gate block connected, SETTLE_CYCLES=2, 1-cycle start -> a_o/b_o sequence 00,01,10,11; busy high cycles 1-12; done pulse in cycle 13 only; pass=1, err_cnt=0, fail_mask=0.
- result_i[0] (and) forced 0 -> mismatch only for vector 11 -> err_cnt=1, fail_mask=7'b0000001, pass=0.
- xor/xnor bits swapped -> every vector mismatches 2 bits -> err_cnt=8, fail_mask=7'b0110000, pass=0.
- start re-pulsed at cycle 5 -> ignored; done still in cycle 13. Separate run: rst asserted at cycle 4 -> outputs immediately zero, state IDLE, no done pulse.
- With the loop macro defined, ERR_CNT_W=4, result_i = ~expected (7 mismatches per vector), start held high -> err_cnt 7, 14, then 15 and held at 15; after start drops, done pulses once with pass=0 and fail_mask=7'h7F.
